// File: rtl/calc_pkg.sv
// ----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the calculator front end: operation codes, parser
// states, the ASCII bytes the parser recognises and small byte classifiers.
// No ports (package).
// ----------------------------------------------------------------------------
package calc_pkg;

    typedef enum logic [1:0] {
        OP_SIN   = 2'd0,
        OP_COS   = 2'd1,
        OP_SQRT  = 2'd2,
        OP_PRIME = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_DIGITS = 2'd0,
        ST_OP     = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [7:0] ASC_0   = 8'h30;
    localparam logic [7:0] ASC_9   = 8'h39;
    localparam logic [7:0] ASC_S   = 8'h73;
    localparam logic [7:0] ASC_C   = 8'h63;
    localparam logic [7:0] ASC_R   = 8'h72;
    localparam logic [7:0] ASC_A   = 8'h61;
    localparam logic [7:0] ASC_BS  = 8'h08;
    localparam logic [7:0] ASC_ESC = 8'h1B;

    typedef struct packed {
        logic hit;
        op_t  op;
    } op_dec_t;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASC_0) && (b <= ASC_9);
    endfunction

    function automatic op_dec_t decode_op(input logic [7:0] b);
        op_dec_t d;
        d = '{hit: 1'b1, op: OP_SIN};
        case (b)
            ASC_S:   d.op  = OP_SIN;
            ASC_C:   d.op  = OP_COS;
            ASC_R:   d.op  = OP_SQRT;
            ASC_A:   d.op  = OP_PRIME;
            default: d.hit = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/uart_cmd_parser_if.sv
// ----------------------------------------------------------------------------
// uart_cmd_parser_if
// Byte-in / command-out bundle of the command parser.
//   rx_data, rx_valid : byte stream from the UART receiver (strobe per byte)
//   cmd_valid/ready   : command handshake towards the function units
//   cmd_value/op/ndig : binary operand, operation code, digits typed
//   err               : one-cycle pulse for each rejected byte
// Modports: slave = the parser, master = the environment around it.
// ----------------------------------------------------------------------------
interface uart_cmd_parser_if
    import calc_pkg::*;
#(
    parameter int VAL_W = 10
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [VAL_W-1:0] cmd_value;
    op_t              cmd_op;
    logic [2:0]       cmd_ndig;
    logic             err;

    modport slave (
        input  rx_data, rx_valid, cmd_ready,
        output cmd_valid, cmd_value, cmd_op, cmd_ndig, err
    );

    modport master (
        output rx_data, rx_valid, cmd_ready,
        input  cmd_valid, cmd_value, cmd_op, cmd_ndig, err
    );
endinterface

// File: rtl/uart_cmd_parser_bcd_to_bin.sv
// ----------------------------------------------------------------------------
// bcd_to_bin
// Combinational BCD to binary conversion of the parser's digit buffer.
//   bcd_i : NUM_DIGITS packed BCD digits, digit 0 (least significant) in [3:0]
//   bin_o : binary value sum(d_i * 10^i), VAL_W bits
// ----------------------------------------------------------------------------
module bcd_to_bin #(
    parameter int NUM_DIGITS = 3,
    parameter int VAL_W      = 10
) (
    input  logic [4*NUM_DIGITS-1:0] bcd_i,
    output logic [VAL_W-1:0]        bin_o
);
    logic [VAL_W-1:0] acc;

    // Horner evaluation from the most significant digit down.
    // NOTE: blocking assignments here on purpose -- acc is a running
    // intermediate within one evaluation, not state; it gets a default first
    // so no latch is inferred.
    always_comb begin
        acc = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            acc = VAL_W'(acc * VAL_W'(10)) + VAL_W'(bcd_i[4*i +: 4]);
        end
        bin_o = acc;
    end
endmodule

// File: rtl/uart_cmd_parser.sv
// ----------------------------------------------------------------------------
// uart_cmd_parser
// Turns an ASCII byte stream ("123s") into one calculator command: up to
// NUM_DIGITS decimal digits followed by an op char (s/c/r/a). The command is
// presented as binary value + op code and held until the consumer accepts it.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low reset
//   bus   : uart_cmd_parser_if.slave (rx byte strobe in, command handshake
//           out, err pulse out)
// Build option: define CMD_PARSER_EDIT_EN to enable line editing
// (backspace 0x08 drops the last digit, ESC 0x1B clears the entry).
// ----------------------------------------------------------------------------
module uart_cmd_parser
    import calc_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int VAL_W      = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_cmd_parser_if.slave     bus
);
    localparam int         BUF_W = 4 * NUM_DIGITS;
    localparam logic [2:0] ND_C  = 3'(NUM_DIGITS);

    state_t           state_q;
    logic [BUF_W-1:0] digits_q;
    logic [2:0]       cnt_q;
    logic             cmd_valid_q;
    logic [VAL_W-1:0] cmd_value_q;
    op_t              cmd_op_q;
    logic [2:0]       cmd_ndig_q;
    logic             err_q;

    logic [BUF_W-1:0] digits_push_d;   // buffer with the new digit appended
    logic [BUF_W-1:0] digits_pop_d;    // buffer with the newest digit removed
    logic [2:0]       cnt_inc_d;
    logic [VAL_W-1:0] bin_value;
    logic             rx_is_digit;
    op_dec_t          op_dec;

    assign rx_is_digit = is_digit(bus.rx_data);
    assign op_dec      = decode_op(bus.rx_data);
    assign cnt_inc_d   = cnt_q + 3'd1;

    // Newest digit lives in [3:0], so typed order maps directly onto powers
    // of ten without tracking the count inside the converter.
    always_comb begin
        digits_push_d      = digits_q << 4;
        digits_push_d[3:0] = bus.rx_data[3:0];
        digits_pop_d       = digits_q >> 4;
    end

    bcd_to_bin #(.NUM_DIGITS(NUM_DIGITS), .VAL_W(VAL_W)) u_bcd_to_bin (
        .bcd_i (digits_q),
        .bin_o (bin_value)
    );

    // NOTE: all state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_DIGITS;
            digits_q    <= '0;
            cnt_q       <= '0;
            cmd_valid_q <= 1'b0;
            cmd_value_q <= '0;
            cmd_op_q    <= OP_SIN;
            cmd_ndig_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_DIGITS: begin
                    if (bus.rx_valid) begin
                        if (rx_is_digit) begin
                            digits_q <= digits_push_d;
                            cnt_q    <= cnt_inc_d;
                            if (cnt_inc_d == ND_C) state_q <= ST_OP;
                        end else if (op_dec.hit && cnt_q != 3'd0) begin
                            cmd_valid_q <= 1'b1;
                            cmd_value_q <= bin_value;
                            cmd_op_q    <= op_dec.op;
                            cmd_ndig_q  <= cnt_q;
                            state_q     <= ST_HOLD;
`ifdef CMD_PARSER_EDIT_EN
                        end else if (bus.rx_data == ASC_BS && cnt_q != 3'd0) begin
                            digits_q <= digits_pop_d;
                            cnt_q    <= cnt_q - 3'd1;
                        end else if (bus.rx_data == ASC_ESC) begin
                            digits_q <= '0;
                            cnt_q    <= '0;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_OP: begin
                    // Buffer is full here, so count is NUM_DIGITS (>= 1).
                    if (bus.rx_valid) begin
                        if (op_dec.hit) begin
                            cmd_valid_q <= 1'b1;
                            cmd_value_q <= bin_value;
                            cmd_op_q    <= op_dec.op;
                            cmd_ndig_q  <= cnt_q;
                            state_q     <= ST_HOLD;
`ifdef CMD_PARSER_EDIT_EN
                        end else if (bus.rx_data == ASC_BS) begin
                            digits_q <= digits_pop_d;
                            cnt_q    <= cnt_q - 3'd1;
                            state_q  <= ST_DIGITS;
                        end else if (bus.rx_data == ASC_ESC) begin
                            digits_q <= '0;
                            cnt_q    <= '0;
                            state_q  <= ST_DIGITS;
`endif
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_HOLD: begin
                    // Any byte here is dropped, even one arriving with the
                    // handshake; the next entry starts strictly afterwards.
                    if (bus.rx_valid) err_q <= 1'b1;
                    if (bus.cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        digits_q    <= '0;
                        cnt_q       <= '0;
                        state_q     <= ST_DIGITS;
                    end
                end
                default: state_q <= ST_DIGITS;
            endcase
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_value = cmd_value_q;
    assign bus.cmd_op    = cmd_op_q;
    assign bus.cmd_ndig  = cmd_ndig_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_uart_cmd_parser.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_parser
// Directed bench for uart_cmd_parser (NUM_DIGITS=3, VAL_W=10). Expected
// commands are queued when the op byte is sent and compared when the parser
// presents them. Honours CMD_PARSER_EDIT_EN for the backspace scenario.
// ----------------------------------------------------------------------------
module tb_uart_cmd_parser;
    import calc_pkg::*;

    localparam int ND = 3;
    localparam int VW = 10;

    typedef struct {
        logic [31:0] value;
        logic [31:0] op;
        logic [31:0] ndig;
    } exp_cmd_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_cmd_t sb[$];

    always #5 clk = ~clk;

    uart_cmd_parser_if #(.VAL_W(VW)) bus ();

    uart_cmd_parser #(.NUM_DIGITS(ND), .VAL_W(VW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Byte is presented for one cycle; err is sampled the cycle after.
    task automatic send(input logic [7:0] b, input logic exp_err, input string tag);
        @(negedge clk);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.rx_data  = ASC_0 + 8'd5;   // stale data while idle must be ignored
        check({tag, " err"}, 32'(bus.err), 32'(exp_err));
    endtask

    task automatic push_cmd(input int value, input int op, input int ndig);
        exp_cmd_t e;
        e.value = 32'(value);
        e.op    = 32'(op);
        e.ndig  = 32'(ndig);
        sb.push_back(e);
    endtask

    // Called right after the op byte: the command must already be valid.
    task automatic expect_cmd(input string tag);
        exp_cmd_t e;
        check({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, " valid"}, 32'(bus.cmd_valid), 32'd1);
            check({tag, " value"}, 32'(bus.cmd_value), e.value);
            check({tag, " op"},    32'(bus.cmd_op),    e.op);
            check({tag, " ndig"},  32'(bus.cmd_ndig),  e.ndig);
        end
    endtask

    task automatic accept(input string tag);
        @(negedge clk);
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        check({tag, " valid_drop"}, 32'(bus.cmd_valid), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " valid"}, 32'(bus.cmd_valid), 32'd0);
        check({tag, " value"}, 32'(bus.cmd_value), 32'd0);
        check({tag, " op"},    32'(bus.cmd_op),    32'd0);
        check({tag, " ndig"},  32'(bus.cmd_ndig),  32'd0);
        check({tag, " err"},   32'(bus.err),       32'd0);
    endtask

    initial begin
        bus.rx_data   = 8'h00;
        bus.rx_valid  = 1'b0;
        bus.cmd_ready = 1'b0;

        // Reset state
        #22;
        check_idle_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // "123s" -> 123 / sin / 3 digits
        send("1", 1'b0, "t1 d1");
        send("2", 1'b0, "t1 d2");
        send("3", 1'b0, "t1 d3");
        push_cmd(123, 0, 3);
        send("s", 1'b0, "t1 op");
        expect_cmd("t1");
        accept("t1");

        // "7r" -> 7 / sqrt / 1 digit
        send("7", 1'b0, "t2 d1");
        push_cmd(7, 2, 1);
        send("r", 1'b0, "t2 op");
        expect_cmd("t2");
        accept("t2");

        // Op first, invalid byte, then buffer full and extra digit rejected
        send("a", 1'b1, "t3 op_no_digits");
        send("4", 1'b0, "t3 d1");
        send("x", 1'b1, "t3 bad_byte");
        send("5", 1'b0, "t3 d2");
        send("6", 1'b0, "t3 d3");
        send("7", 1'b1, "t3 digit_when_full");
        push_cmd(456, 1, 3);
        send("c", 1'b0, "t3 op");
        expect_cmd("t3");
        accept("t3");

        // Backpressure: command held for 5 cycles, byte in hold rejected
        send("9", 1'b0, "t4 d1");
        send("9", 1'b0, "t4 d2");
        send("9", 1'b0, "t4 d3");
        push_cmd(999, 3, 3);
        send("a", 1'b0, "t4 op");
        expect_cmd("t4");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4 hold valid", 32'(bus.cmd_valid), 32'd1);
            check("t4 hold value", 32'(bus.cmd_value), 32'd999);
        end
        send("5", 1'b1, "t4 byte_in_hold");
        check("t4 after_drop value", 32'(bus.cmd_value), 32'd999);
        check("t4 after_drop ndig",  32'(bus.cmd_ndig),  32'd3);
        accept("t4");
        send("8", 1'b0, "t4b d1");
        push_cmd(8, 0, 1);
        send("s", 1'b0, "t4b op");
        expect_cmd("t4b");

        // Byte coinciding with the handshake is dropped, not captured
        @(negedge clk);
        bus.cmd_ready = 1'b1;
        bus.rx_data   = "1";
        bus.rx_valid  = 1'b1;
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        bus.rx_valid  = 1'b0;
        check("t5 coincide err",   32'(bus.err),       32'd1);
        check("t5 coincide valid", 32'(bus.cmd_valid), 32'd0);
        send("2", 1'b0, "t5 d1");
        push_cmd(2, 2, 1);
        send("r", 1'b0, "t5 op");
        expect_cmd("t5");
        accept("t5");

        // Reset mid-entry discards the partial command and clears outputs
        send("1", 1'b0, "t6 d1");
        send("2", 1'b0, "t6 d2");
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("t6 mid_reset");
        reset = 1'b1;
        send("3", 1'b0, "t6 d3");
        push_cmd(3, 3, 1);
        send("a", 1'b0, "t6 op");
        expect_cmd("t6");
        accept("t6");

        // Backspace handling depends on the build option
        send("1", 1'b0, "t7 d1");
        send("2", 1'b0, "t7 d2");
`ifdef CMD_PARSER_EDIT_EN
        send(ASC_BS, 1'b0, "t7 backspace");
        send("5", 1'b0, "t7 d3");
        push_cmd(15, 0, 2);
`else
        send(ASC_BS, 1'b1, "t7 backspace");
        send("5", 1'b0, "t7 d3");
        push_cmd(125, 0, 3);
`endif
        send("s", 1'b0, "t7 op");
        expect_cmd("t7");
        accept("t7");

        check("sb drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
